// File: rtl/instruction_fetch.sv
// Instruction fetch stage: latches the PC on a fetch request, reads instruction
// memory, and holds the returned word for decode. Also reports misaligned-PC and
// memory-timeout faults, and drains a response that is still outstanding after a flush.
module instruction_fetch #(
  parameter int          ADDR_W      = 64,
  parameter int          INSTR_W     = 32,
  parameter logic [2:0]  FETCH_STATE = 3'b000,
  parameter int          TIMEOUT     = 255,
  parameter int          TIMEOUT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [2:0]         state,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  output logic [ADDR_W-1:0]  pc_plus_4,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               fetch_busy,
  output logic               fetch_fault,
  output logic [1:0]         fault_cause,
  output logic [2:0]         fsm_state
);

  // Handshake rules: a request transfers on a cycle where imem_req_valid and
  // imem_req_ready are both high, and imem_req_addr stays stable until it does.
  // A response is a single-cycle imem_resp_valid pulse with no back-pressure.
  // Decode takes the instruction on a cycle where instr_valid and instr_ready are both high.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4,
    S_DRAIN = 3'd5
  } fetch_state_e;

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(TIMEOUT);
  localparam logic [ADDR_W-1:0]    FOUR        = ADDR_W'(4);
  localparam logic [1:0]           CAUSE_NONE  = 2'b00;
  localparam logic [1:0]           CAUSE_ALIGN = 2'b01;
  localparam logic [1:0]           CAUSE_TIME  = 2'b10;

  fetch_state_e           cur;
  logic [ADDR_W-1:0]      fetch_pc;
  logic [INSTR_W-1:0]     instr_q;
  logic [ADDR_W-1:0]      instr_pc_q;
  logic [TIMEOUT_W-1:0]   counter;
  logic [1:0]             cause_q;
  logic                   timed_out;
  logic [TIMEOUT_W-1:0]   counter_next;

  assign timed_out    = (counter == TIMEOUT_VAL);
  // Holding at TIMEOUT keeps a flush late in WAIT from wrapping the drain window.
  assign counter_next = timed_out ? counter : counter + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur        <= S_IDLE;
      fetch_pc   <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      counter    <= '0;
      cause_q    <= CAUSE_NONE;
    end else begin
      case (cur)
        S_IDLE: begin
          if (state == FETCH_STATE) begin
            fetch_pc <= pc;
            if (pc[1:0] != 2'b00) begin
              cur     <= S_FAULT;
              cause_q <= CAUSE_ALIGN;
            end else begin
              cur <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (flush) begin
            cur <= S_IDLE;
          end else if (imem_req_ready) begin
            cur     <= S_WAIT;
            counter <= '0;
          end
        end
        S_WAIT: begin
          counter <= counter_next;
          if (flush) begin
            // A response arriving in the flush cycle is the one in flight, so nothing is left to drain.
            cur <= imem_resp_valid ? S_IDLE : S_DRAIN;
          end else if (imem_resp_valid) begin
            instr_q    <= imem_resp_data;
            instr_pc_q <= fetch_pc;
            cur        <= S_HOLD;
          end else if (timed_out) begin
            cur     <= S_FAULT;
            cause_q <= CAUSE_TIME;
          end
        end
        S_HOLD: begin
          if (flush || instr_ready) begin
            cur <= S_IDLE;
          end
        end
        S_FAULT: begin
          if (flush) begin
            cur     <= S_IDLE;
            cause_q <= CAUSE_NONE;
          end
        end
        S_DRAIN: begin
          counter <= counter_next;
          if (imem_resp_valid || timed_out) begin
            cur <= S_IDLE;
          end
        end
        default: begin
          cur <= S_IDLE;
        end
      endcase
    end
  end

  assign pc_plus_4      = fetch_pc + FOUR;
  assign imem_req_addr  = fetch_pc;
  assign imem_req_valid = (cur == S_REQ);
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_valid    = (cur == S_HOLD);
  assign fetch_busy     = (cur == S_REQ) || (cur == S_WAIT) || (cur == S_DRAIN);
  assign fetch_fault    = (cur == S_FAULT);
  assign fault_cause    = cause_q;
  assign fsm_state      = cur;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: basic fetch, back-pressure, faults,
// flush/drain, reset during a transaction and address wrap.
module tb_instruction_fetch;

  localparam int TIMEOUT = 255;

  logic        clk;
  logic        reset;
  logic [2:0]  state;
  logic [63:0] pc;
  logic        flush;
  logic [63:0] pc_plus_4;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_busy;
  logic        fetch_fault;
  logic [1:0]  fault_cause;
  logic [2:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .state           (state),
    .pc              (pc),
    .flush           (flush),
    .pc_plus_4       (pc_plus_4),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .fetch_busy      (fetch_busy),
    .fetch_fault     (fetch_fault),
    .fault_cause     (fault_cause),
    .fsm_state       (fsm_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues a fetch from IDLE and leaves the DUT in WAIT with ready dropped.
  task automatic start_fetch(input logic [63:0] addr);
    pc = addr;
    state = 3'b000;
    imem_req_ready = 1'b1;
    tick();
    state = 3'b111;
    tick();
    imem_req_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    state = 3'b111;
    pc = '0;
    flush = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = '0;
    instr_ready = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_pc_plus_4", pc_plus_4, 64'd4);
    check("rst_busy", fetch_busy, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_cause", fault_cause, 0);
    check("rst_instr", instr, 0);
    tick();
    tick();
    reset = 1'b1;

    // Basic fetch
    pc = 64'h1000;
    state = 3'b000;
    imem_req_ready = 1'b1;
    tick();
    state = 3'b111;
    check("basic_req_valid", imem_req_valid, 1);
    check("basic_req_addr", imem_req_addr, 64'h1000);
    check("basic_pc_plus_4", pc_plus_4, 64'h1004);
    check("basic_busy", fetch_busy, 1);
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h00500093;
    check("basic_wait_no_req", imem_req_valid, 0);
    tick();
    imem_resp_valid = 1'b0;
    check("basic_instr_valid", instr_valid, 1);
    check("basic_instr", instr, 32'h00500093);
    check("basic_instr_pc", instr_pc, 64'h1000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("basic_idle_valid", instr_valid, 0);
    check("basic_idle_busy", fetch_busy, 0);

    // Back-pressure on request, response and decode
    pc = 64'h3000;
    state = 3'b000;
    imem_req_ready = 1'b0;
    tick();
    state = 3'b111;
    pc = 64'h9990;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", imem_req_valid, 1);
      check("bp_req_addr", imem_req_addr, 64'h3000);
      tick();
    end
    imem_req_ready = 1'b1;
    check("bp_req_valid_acc", imem_req_valid, 1);
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_wait_no_req", imem_req_valid, 0);
      check("bp_wait_busy", fetch_busy, 1);
      check("bp_wait_addr", imem_req_addr, 64'h3000);
      tick();
    end
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEADBEEF;
    tick();
    imem_resp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("bp_hold_valid", instr_valid, 1);
      check("bp_hold_instr", instr, 32'hDEADBEEF);
      check("bp_hold_pc", instr_pc, 64'h3000);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_released", instr_valid, 0);

    // Misaligned PC
    pc = 64'h1002;
    state = 3'b000;
    tick();
    check("mis_fault", fetch_fault, 1);
    check("mis_cause", fault_cause, 2'b01);
    check("mis_no_req", imem_req_valid, 0);
    check("mis_addr", imem_req_addr, 64'h1002);
    check("mis_pc_plus_4", pc_plus_4, 64'h1006);
    tick();
    check("mis_sticky", fetch_fault, 1);
    check("mis_no_req2", imem_req_valid, 0);
    flush = 1'b1;
    state = 3'b111;
    tick();
    flush = 1'b0;
    check("mis_flush_fault", fetch_fault, 0);
    check("mis_flush_cause", fault_cause, 0);

    // Timeout: fault lands exactly TIMEOUT+1 edges after accept
    start_fetch(64'h4000);
    for (int i = 0; i < TIMEOUT; i++) tick();
    check("to_not_yet", fetch_fault, 0);
    check("to_still_busy", fetch_busy, 1);
    tick();
    check("to_fault", fetch_fault, 1);
    check("to_cause", fault_cause, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("to_flush_cause", fault_cause, 0);

    // Response on the timeout cycle wins
    start_fetch(64'h5000);
    for (int i = 0; i < TIMEOUT; i++) tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h12345678;
    tick();
    imem_resp_valid = 1'b0;
    check("tor_no_fault", fetch_fault, 0);
    check("tor_valid", instr_valid, 1);
    check("tor_instr", instr, 32'h12345678);
    check("tor_pc", instr_pc, 64'h5000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Flush in WAIT, response two cycles later is drained
    start_fetch(64'h6000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_drain_busy", fetch_busy, 1);
    check("fl_drain_valid", instr_valid, 0);
    check("fl_drain_no_req", imem_req_valid, 0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBADBAD00;
    tick();
    imem_resp_valid = 1'b0;
    check("fl_after_valid", instr_valid, 0);
    check("fl_after_busy", fetch_busy, 0);
    check("fl_instr_kept", instr, 32'h12345678);
    start_fetch(64'h2000);
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h00A00113;
    tick();
    imem_resp_valid = 1'b0;
    check("fl_next_valid", instr_valid, 1);
    check("fl_next_instr", instr, 32'h00A00113);
    check("fl_next_pc", instr_pc, 64'h2000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Flush and response in the same WAIT cycle go straight to IDLE
    start_fetch(64'h7000);
    flush = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hCAFEF00D;
    tick();
    flush = 1'b0;
    imem_resp_valid = 1'b0;
    check("flr_busy", fetch_busy, 0);
    check("flr_valid", instr_valid, 0);
    check("flr_instr_kept", instr, 32'h00A00113);

    // Reset during WAIT
    start_fetch(64'h8000);
    check("rw_busy_before", fetch_busy, 1);
    reset = 1'b0;
    #1;
    check("rw_busy", fetch_busy, 0);
    check("rw_pc_plus_4", pc_plus_4, 64'd4);
    check("rw_addr", imem_req_addr, 0);
    check("rw_instr", instr, 0);
    check("rw_instr_pc", instr_pc, 0);
    check("rw_cause", fault_cause, 0);
    tick();
    reset = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h55555555;
    tick();
    imem_resp_valid = 1'b0;
    check("rw_late_valid", instr_valid, 0);
    check("rw_late_instr", instr, 0);

    // Address wrap
    pc = 64'hFFFF_FFFF_FFFF_FFFC;
    state = 3'b000;
    tick();
    state = 3'b111;
    check("wrap_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc_plus_4", pc_plus_4, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wrap_flush_idle", fetch_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
